rgb2gray_pipe: RTL and testbench
================================

Name: rgb2gray_pipe

Overview:
Parametrised, pipelined colour-to-grayscale converter for the input module. It sits between the pixel source and the filter stages.
- Accepts one RGB pixel per cycle under valid_i.
- Produces one gray pixel per valid_o after a fixed 3-cycle latency.
- Supports four conversion modes, including runtime-programmable coefficients.
- Carries the frame-end flag (done_i/done_o) through the same pipeline, aligned to the last pixel.

Parameters:
DATA_W, 8, bit width of each colour channel and of the gray output
COEF_W, 8, coefficient width; coefficients are unsigned fixed point with COEF_W fractional bits
DEF_CR, 77, reset value of coef_r register (BT.601 luma x256)
DEF_CG, 150, reset value of coef_g register
DEF_CB, 29, reset value of coef_b register

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
valid_i  in  1  red_i/green_i/blue_i hold a pixel this cycle
red_i  in  DATA_W  red channel
green_i  in  DATA_W  green channel
blue_i  in  DATA_W  blue channel
done_i  in  1  frame end; may coincide with the last valid_i pixel or follow it
mode_i  in  2  0 = weighted luma (coef regs), 1 = (R+2G+B)/4, 2 = max(R,G,B), 3 = green only
coef_we_i  in  1  write coef_r/g/b from coef_*_i
coef_r_i, coef_g_i, coef_b_i  in  COEF_W each  coefficient write data
grayscale_o  out  DATA_W  gray pixel
valid_o  out  1  grayscale_o valid
done_o  out  1  one-cycle frame-end pulse
busy_o  out  1  high while state is not IDLE

Behaviour:
- Reset: every pipeline register, grayscale_o, valid_o, done_o and busy_o are 0; coefs load DEF_CR/DEF_CG/DEF_CB; active_mode loads 0; FSM goes to IDLE. Reset mid-frame discards all in-flight pixels and raises no done_o.
- Pipeline, latency 3, no backpressure:
  - S1 registers per-channel products or selected operands.
  - S2 registers the sum or max.
  - S3 registers the rounded, saturated result.
  - valid and done shift alongside the data, so valid_o(t+3) = valid_i(t) and done_o(t+3) = done_i(t).
- Mode 0 arithmetic:
  - Products are DATA_W+COEF_W bits wide; the sum is DATA_W+COEF_W+2 bits.
  - Result = (sum + 2^(COEF_W-1)) >> COEF_W.
  - Saturate to 2^DATA_W-1 if the result exceeds it.
- Mode 1: (R + 2G + B + 2) >> 2. The sum is DATA_W+2 bits wide; the result never exceeds the maximum.
- Mode 2: max of the three channels; ties are irrelevant.
- Mode 3: G passes through the pipeline unchanged.
- FSM states:
  - IDLE: on valid_i, latch mode_i into active_mode, go to ACTIVE. A pixel arriving in this same cycle uses the newly latched mode.
  - ACTIVE: on done_i, go to FLUSH.
  - FLUSH: count 3 cycles, then go to IDLE. The count is chosen so the cycle done_o is asserted is the last FLUSH cycle.
- Mode changes: mode_i is ignored outside IDLE, so a frame never mixes modes.
- done_i while in IDLE (empty frame): go straight to FLUSH; done_o pulses 3 cycles later with valid_o low.
- valid_i and done_i high in the same cycle: the pixel is processed and done_o coincides with its valid_o.
- valid_i in FLUSH: processed with active_mode. The spec treats this as a protocol violation; add an assertion only, no functional handling.
- Coefficient writes:
  - coef_we_i is accepted only in IDLE; writes in ACTIVE or FLUSH are dropped.
  - Coefficients take effect on the next latched frame.
- Non-valid cycles: grayscale_o holds its last value when valid_o is 0.

Decomposition:
- Shared package rgb2gray_pkg holds:
  - mode encodings MODE_LUMA, MODE_AVG, MODE_MAX, MODE_GREEN;
  - the PIPE_LAT = 3 constant;
  - FSM state typedef (IDLE, ACTIVE, FLUSH);
  - BT.601 default coefficient constants.
- One natural sub-module, rgb2gray_pipe_dp: a datapath-only 3-stage arithmetic pipeline carrying valid/done. The top level keeps the FSM, mode latch and coefficient registers.

Test Plan:
- Mode 0, default coefs; R=100, G=150, B=50 with valid_i -> grayscale_o=124 and valid_o exactly 3 cycles later.
- Mode 0; R=G=B=255, then coef write 255/255/255 in IDLE, then the same pixel -> 255 both times; the second result is a saturation case, with a raw value of 762 clamped to 255.
- Mode 1, R=100, G=150, B=50 -> 113. Mode 2, same pixel -> 150. Mode 3, same pixel -> 150.
- Frame of 4 back-to-back pixels with done_i on the 4th; mode_i toggled mid-frame:
  - all 4 results use the latched mode;
  - done_o coincides with the 4th valid_o;
  - busy_o drops the cycle after done_o.
- done_i in IDLE with no pixels -> done_o pulse 3 cycles later, valid_o stays 0; coef write during ACTIVE -> coefficient registers unchanged.
- Assert rst mid-frame with 2 pixels in flight:
  - all outputs go to 0 immediately and asynchronously;
  - no valid_o or done_o after release;
  - the next frame converts correctly.

Source files
------------

// File: rtl/rgb2gray_pkg.sv
// Shared constants and types for the RGB to grayscale pipeline.
// Mode encodings, pipeline latency, FSM states, BT.601 defaults.
package rgb2gray_pkg;

  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {
    MODE_LUMA  = 2'd0,
    MODE_AVG   = 2'd1,
    MODE_MAX   = 2'd2,
    MODE_GREEN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  localparam int BT601_CR = 77;
  localparam int BT601_CG = 150;
  localparam int BT601_CB = 29;

endpackage

// File: rtl/rgb2gray_pipe_dp.sv
// Three-stage grayscale arithmetic: operands/products, sum/max,
// round/saturate. Valid and done ride alongside the data.
module rgb2gray_pipe_dp
  import rgb2gray_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              pix_done,
  input  mode_e             mode,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  input  logic [COEF_W-1:0] coef_r,
  input  logic [COEF_W-1:0] coef_g,
  input  logic [COEF_W-1:0] coef_b,
  output logic [DATA_W-1:0] gray,
  output logic              gray_valid,
  output logic              gray_done
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int RES_W  = SUM_W - COEF_W;
  localparam int HALF   = 1 << (COEF_W - 1);
  localparam logic [DATA_W-1:0] MAXV = {DATA_W{1'b1}};

  logic [PROD_W-1:0] op_r, op_g, op_b;
  logic [PROD_W-1:0] s1_r, s1_g, s1_b;
  mode_e             s1_mode, s2_mode;
  logic              s1_valid, s1_done;
  logic              s2_valid, s2_done;
  logic [PROD_W-1:0] mx;
  logic [SUM_W-1:0]  nxt_sum, s2_sum;
  logic [RES_W-1:0]  luma;
  logic [DATA_W-1:0] res;

  always_comb begin
    op_r = PROD_W'(red);
    op_g = PROD_W'(green);
    op_b = PROD_W'(blue);
    unique case (mode)
      MODE_LUMA: begin
        op_r = PROD_W'(red) * PROD_W'(coef_r);
        op_g = PROD_W'(green) * PROD_W'(coef_g);
        op_b = PROD_W'(blue) * PROD_W'(coef_b);
      end
      MODE_AVG:   op_g = PROD_W'(green) << 1;
      MODE_MAX:   ;
      MODE_GREEN: ;
      default:    ;
    endcase
  end

  always_comb begin
    mx = (s1_r >= s1_g) ? s1_r : s1_g;
    mx = (mx >= s1_b) ? mx : s1_b;
    unique case (s1_mode)
      MODE_MAX:   nxt_sum = SUM_W'(mx);
      MODE_GREEN: nxt_sum = SUM_W'(s1_g);
      default:
        nxt_sum = SUM_W'(s1_r) + SUM_W'(s1_g) + SUM_W'(s1_b);
    endcase
  end

  always_comb begin
    luma = RES_W'((s2_sum + SUM_W'(HALF)) >> COEF_W);
    unique case (s2_mode)
      MODE_LUMA:
        res = (luma > RES_W'(MAXV)) ? MAXV : DATA_W'(luma);
      MODE_AVG: res = DATA_W'((s2_sum + SUM_W'(2)) >> 2);
      default:  res = DATA_W'(s2_sum);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r       <= '0;
      s1_g       <= '0;
      s1_b       <= '0;
      s1_mode    <= MODE_LUMA;
      s1_valid   <= 1'b0;
      s1_done    <= 1'b0;
      s2_sum     <= '0;
      s2_mode    <= MODE_LUMA;
      s2_valid   <= 1'b0;
      s2_done    <= 1'b0;
      gray       <= '0;
      gray_valid <= 1'b0;
      gray_done  <= 1'b0;
    end else begin
      s1_r       <= op_r;
      s1_g       <= op_g;
      s1_b       <= op_b;
      s1_mode    <= mode;
      s1_valid   <= pix_valid;
      s1_done    <= pix_done;
      s2_sum     <= nxt_sum;
      s2_mode    <= s1_mode;
      s2_valid   <= s1_valid;
      s2_done    <= s1_done;
      if (s2_valid) gray <= res;
      gray_valid <= s2_valid;
      gray_done  <= s2_done;
    end
  end

endmodule

// File: rtl/rgb2gray_pipe.sv
// Grayscale converter top: frame FSM, mode latch, coefficient regs,
// and the arithmetic datapath.
module rgb2gray_pipe
  import rgb2gray_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int DEF_CR = BT601_CR,
  parameter int DEF_CG = BT601_CG,
  parameter int DEF_CB = BT601_CB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] red_i,
  input  logic [DATA_W-1:0] green_i,
  input  logic [DATA_W-1:0] blue_i,
  input  logic              done_i,
  input  logic [1:0]        mode_i,
  input  logic              coef_we_i,
  input  logic [COEF_W-1:0] coef_r_i,
  input  logic [COEF_W-1:0] coef_g_i,
  input  logic [COEF_W-1:0] coef_b_i,
  output logic [DATA_W-1:0] grayscale_o,
  output logic              valid_o,
  output logic              done_o,
  output logic              busy_o
);

  state_e            state, state_n;
  logic [1:0]        flush_cnt;
  mode_e             active_mode, cur_mode;
  logic [COEF_W-1:0] coef_r, coef_g, coef_b;
  logic              idle;

  assign idle   = (state == IDLE);
  assign busy_o = !idle;

  // The first pixel of a frame already uses the mode being latched.
  assign cur_mode = (idle && valid_i) ? mode_e'(mode_i) : active_mode;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (done_i) state_n = FLUSH;
        else if (valid_i) state_n = ACTIVE;
      end
      ACTIVE: if (done_i) state_n = FLUSH;
      FLUSH:
        if (flush_cnt == 2'(PIPE_LAT - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      active_mode <= MODE_LUMA;
      coef_r      <= COEF_W'(DEF_CR);
      coef_g      <= COEF_W'(DEF_CG);
      coef_b      <= COEF_W'(DEF_CB);
    end else begin
      state     <= state_n;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      if (idle && valid_i) active_mode <= mode_e'(mode_i);
      if (idle && coef_we_i) begin
        coef_r <= coef_r_i;
        coef_g <= coef_g_i;
        coef_b <= coef_b_i;
      end
    end
  end

  no_pixel_in_flush: assert property (
    @(posedge clk) disable iff (rst) !(state == FLUSH && valid_i));

  rgb2gray_pipe_dp #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (valid_i),
    .pix_done  (done_i),
    .mode      (cur_mode),
    .red       (red_i),
    .green     (green_i),
    .blue      (blue_i),
    .coef_r    (coef_r),
    .coef_g    (coef_g),
    .coef_b    (coef_b),
    .gray      (grayscale_o),
    .gray_valid(valid_o),
    .gray_done (done_o)
  );

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Directed bench for rgb2gray_pipe: vector table of single-pixel
// frames plus hand-written frame, flush and reset sequences.
module tb_rgb2gray_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0;
  logic [7:0] red_i = '0, green_i = '0, blue_i = '0;
  logic       done_i = 1'b0;
  logic [1:0] mode_i = '0;
  logic       coef_we_i = 1'b0;
  logic [7:0] coef_r_i = '0, coef_g_i = '0, coef_b_i = '0;
  logic [7:0] grayscale_o;
  logic       valid_o, done_o, busy_o;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  rgb2gray_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .red_i      (red_i),
    .green_i    (green_i),
    .blue_i     (blue_i),
    .done_i     (done_i),
    .mode_i     (mode_i),
    .coef_we_i  (coef_we_i),
    .coef_r_i   (coef_r_i),
    .coef_g_i   (coef_g_i),
    .coef_b_i   (coef_b_i),
    .grayscale_o(grayscale_o),
    .valid_o    (valid_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    int mode;
    int r;
    int g;
    int b;
    int exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(string nm, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic idle_in();
    valid_i   = 1'b0;
    done_i    = 1'b0;
    coef_we_i = 1'b0;
  endtask

  // One-pixel frame: pixel and done together, result 3 cycles later.
  task automatic single(string nm, int m, int r, int g, int b, int exp);
    @(negedge clk);
    valid_i = 1'b1;
    done_i  = 1'b1;
    mode_i  = 2'(m);
    red_i   = 8'(r);
    green_i = 8'(g);
    blue_i  = 8'(b);
    @(negedge clk);
    idle_in();
    mode_i = ~2'(m);
    @(negedge clk);
    chk({nm, " early valid"}, int'(valid_o), 0);
    @(negedge clk);
    chk({nm, " valid"}, int'(valid_o), 1);
    chk({nm, " gray"}, int'(grayscale_o), exp);
    chk({nm, " done"}, int'(done_o), 1);
    chk({nm, " busy at done"}, int'(busy_o), 1);
    @(negedge clk);
    chk({nm, " busy after"}, int'(busy_o), 0);
  endtask

  task automatic wr_coef(int cr, int cg, int cb);
    @(negedge clk);
    coef_we_i = 1'b1;
    coef_r_i  = 8'(cr);
    coef_g_i  = 8'(cg);
    coef_b_i  = 8'(cb);
    @(negedge clk);
    coef_we_i = 1'b0;
  endtask

  int fr[4]   = '{10, 100, 255, 3};
  int fg[4]   = '{20, 150, 0, 2};
  int fb[4]   = '{30, 50, 7, 1};
  int fm[4]   = '{2, 0, 1, 3};
  int fexp[4] = '{30, 150, 255, 3};

  initial begin
    int seen_v;
    int seen_d;
    vecs[0] = '{0, 100, 150, 50, 124};
    vecs[1] = '{0, 255, 255, 255, 255};
    vecs[2] = '{0, 0, 0, 0, 0};
    vecs[3] = '{1, 100, 150, 50, 113};
    vecs[4] = '{2, 100, 150, 50, 150};
    vecs[5] = '{3, 100, 150, 50, 150};
    vecs[6] = '{2, 200, 10, 90, 200};
    vecs[7] = '{1, 255, 255, 255, 255};

    repeat (2) @(negedge clk);
    chk("reset gray", int'(grayscale_o), 0);
    chk("reset valid", int'(valid_o), 0);
    chk("reset done", int'(done_o), 0);
    chk("reset busy", int'(busy_o), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      single($sformatf("vec%0d", i), vecs[i].mode, vecs[i].r,
             vecs[i].g, vecs[i].b, vecs[i].exp);

    // Four-pixel frame, mode toggled mid-frame, coef write dropped.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3 && i <= 6) begin
        chk($sformatf("frame px%0d valid", i - 3), int'(valid_o), 1);
        chk($sformatf("frame px%0d gray", i - 3), int'(grayscale_o),
            fexp[i-3]);
        chk($sformatf("frame px%0d done", i - 3), int'(done_o),
            (i == 6) ? 1 : 0);
      end
      if (i == 6) chk("frame busy at done", int'(busy_o), 1);
      if (i == 7) chk("frame busy after", int'(busy_o), 0);
      if (i < 4) begin
        valid_i   = 1'b1;
        red_i     = 8'(fr[i]);
        green_i   = 8'(fg[i]);
        blue_i    = 8'(fb[i]);
        mode_i    = 2'(fm[i]);
        done_i    = (i == 3);
        coef_we_i = (i == 1);
        coef_r_i  = '0;
        coef_g_i  = '0;
        coef_b_i  = '0;
      end else begin
        idle_in();
      end
    end
    single("coefs kept", 0, 100, 150, 50, 124);

    // Empty frame.
    @(negedge clk);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    chk("empty valid c1", int'(valid_o), 0);
    @(negedge clk);
    chk("empty done c2", int'(done_o), 0);
    @(negedge clk);
    chk("empty done c3", int'(done_o), 1);
    chk("empty valid c3", int'(valid_o), 0);
    chk("empty gray hold", int'(grayscale_o), 124);
    chk("empty busy c3", int'(busy_o), 1);
    @(negedge clk);
    chk("empty busy c4", int'(busy_o), 0);

    // Saturation with full-scale coefficients.
    wr_coef(255, 255, 255);
    single("sat 255", 0, 255, 255, 255, 255);
    single("sat small", 0, 1, 1, 1, 3);

    // Reset with two pixels in flight.
    @(negedge clk);
    valid_i = 1'b1;
    mode_i  = 2'd0;
    red_i   = 8'd100;
    green_i = 8'd150;
    blue_i  = 8'd50;
    @(negedge clk);
    red_i = 8'd10;
    @(negedge clk);
    valid_i = 1'b0;
    chk("pre-reset busy", int'(busy_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst gray", int'(grayscale_o), 0);
    chk("async rst valid", int'(valid_o), 0);
    chk("async rst done", int'(done_o), 0);
    chk("async rst busy", int'(busy_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_v = 0;
    seen_d = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid_o) seen_v = 1;
      if (done_o) seen_d = 1;
    end
    chk("post-reset no valid", seen_v, 0);
    chk("post-reset no done", seen_d, 0);
    single("post-reset frame", 0, 100, 150, 50, 124);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
